// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding and default widths/addresses,
// also consumed by the datapath.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam int PC_STEP_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter register: synchronous reset, load enable, choice of
// sequential increment or redirect target.
module pc_register #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_STEP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              use_redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            // increment wraps naturally at the register width
            pc <= use_redirect ? redirect_pc : pc + ADDR_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// hands each word with its address to decode over valid/ready.
//
// state | meaning
// IDLE  | just out of reset, fetch starts next cycle
// FETCH | request outstanding at pc, waiting for ack
// HOLD  | ir/ir_pc valid, waiting for consumer
// DRAIN | stale request still outstanding after a redirect, data will be dropped
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t state;
    logic         pc_load;

    assign pc_load = redirect_valid || (state == FETCH && mem_ack);

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_register (
        .clk          (CLK),
        .reset        (Reset),
        .load         (pc_load),
        .use_redirect (redirect_valid),
        .redirect_pc  (redirect_pc),
        .pc           (pc)
    );

    // Outputs are registered alongside the state, so each branch sets the values
    // the next state decodes to; the next fetch address is pc after this edge's update.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    mem_req  <= 1'b1;
                    mem_addr <= redirect_valid ? redirect_pc : pc;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        if (mem_ack) begin
                            state    <= FETCH;
                            mem_addr <= redirect_pc;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        state    <= HOLD;
                        ir       <= mem_rdata;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        mem_req  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect_valid || ir_ready) begin
                        state    <= FETCH;
                        ir_valid <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= redirect_valid ? redirect_pc : pc;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state    <= FETCH;
                        mem_addr <= redirect_valid ? redirect_pc : pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ir_valid <= 1'b0;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule
